// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared RV32I field widths, format codes and encoder state encoding.
package instr_encoder_pkg;
  localparam int OPCODE_SIZE = 7;
  localparam int REG_BITS = 5;
  localparam int FUNC3_BITS = 3;
  localparam int FUNC7_BITS = 7;
  localparam int NO_IMM = 0;
  localparam int FORMAT_I = 1;
  localparam int FORMAT_S = 2;
  localparam int FORMAT_B = 3;
  localparam int FORMAT_U = 4;
  localparam int FORMAT_J = 5;
  typedef enum logic [1:0] {ENC_IDLE, ENC_STREAM, ENC_DRAIN, ENC_FULL} enc_state_t;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: packs RV32I fields into a 32-bit word; err flags unrepresentable immediates when IMM_RANGE_CHECK_EN is defined.
module instr_pack
  import instr_encoder_pkg::*;
#(
  parameter int FMT_BITS = 3
) (
  input  logic [FMT_BITS-1:0]    fmt,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic [REG_BITS-1:0]    rd,
  input  logic [REG_BITS-1:0]    rs1,
  input  logic [REG_BITS-1:0]    rs2,
  input  logic [FUNC3_BITS-1:0]  funct3,
  input  logic [FUNC7_BITS-1:0]  funct7,
  input  logic [31:0]            imm,
  output logic [31:0]            word,
  output logic                   err
);
  always_comb begin
    case (fmt)
      FMT_BITS'(FORMAT_I): word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_BITS'(FORMAT_S): word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_BITS'(FORMAT_B): word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_BITS'(FORMAT_U): word = {imm[31:12], rd, opcode};
      FMT_BITS'(FORMAT_J): word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:             word = {funct7, rs2, rs1, funct3, rd, opcode};
    endcase
  end
`ifdef IMM_RANGE_CHECK_EN
  logic s12, s13, s21;
  assign s12 = imm[31:11] == {21{imm[11]}};
  assign s13 = imm[31:12] == {20{imm[12]}} && !imm[0];
  assign s21 = imm[31:20] == {12{imm[20]}} && !imm[0];
  always_comb
    err = (fmt == FMT_BITS'(FORMAT_I) || fmt == FMT_BITS'(FORMAT_S)) ? !s12 :
          fmt == FMT_BITS'(FORMAT_B) ? !s13 :
          fmt == FMT_BITS'(FORMAT_J) ? !s21 :
          fmt == FMT_BITS'(FORMAT_U) ? |imm[11:0] : 1'b0;
`else
  assign err = 1'b0;
`endif
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams packed RV32I words to instruction memory; IMM_RANGE_CHECK_EN drops out-of-range immediates and sets imm_err.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int FMT_BITS  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_BITS-1:0]   base_addr,
  input  logic                   finish,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FMT_BITS-1:0]    in_fmt,
  input  logic [OPCODE_SIZE-1:0] in_opcode,
  input  logic [REG_BITS-1:0]    in_rd,
  input  logic [REG_BITS-1:0]    in_rs1,
  input  logic [REG_BITS-1:0]    in_rs2,
  input  logic [FUNC3_BITS-1:0]  in_funct3,
  input  logic [FUNC7_BITS-1:0]  in_funct7,
  input  logic [31:0]            in_imm,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [ADDR_BITS-1:0]   wr_addr,
  output logic [31:0]            wr_data,
  output logic [ADDR_BITS-2:0]   count,
  output logic                   busy,
  output logic                   full,
  output logic                   imm_err
);
  enc_state_t state, state_nxt;
  logic [ADDR_BITS-1:0] addr_cnt;
  logic [31:0] word;
  logic err, accept, take, last;
  instr_pack #(.FMT_BITS(FMT_BITS)) u_pack (
    .fmt(in_fmt), .opcode(in_opcode), .rd(in_rd), .rs1(in_rs1), .rs2(in_rs2),
    .funct3(in_funct3), .funct7(in_funct7), .imm(in_imm), .word(word), .err(err)
  );
  assign in_ready = state == ENC_STREAM && !(wr_valid && !wr_ready);
  assign accept = in_valid && in_ready;
  assign take = accept && !err;
  assign last = addr_cnt == {{(ADDR_BITS-2){1'b1}}, 2'b00};
  assign full = state == ENC_FULL;
  assign busy = state != ENC_IDLE || wr_valid;
  always_comb begin
    state_nxt = state;
    if (start) state_nxt = ENC_STREAM;
    else if (state == ENC_STREAM) state_nxt = (take && last) ? ENC_FULL : finish ? ENC_DRAIN : ENC_STREAM;
    else if (state == ENC_DRAIN && !wr_valid) state_nxt = ENC_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ENC_IDLE;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      addr_cnt <= '0;
      count    <= '0;
      imm_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        wr_valid <= 1'b1;
        wr_addr  <= addr_cnt;
        wr_data  <= word;
      end else if (wr_ready) wr_valid <= 1'b0;
      if (start) begin
        addr_cnt <= base_addr & ~ADDR_BITS'(3);
        count    <= '0;
        imm_err  <= 1'b0;
      end else begin
        // the top address is terminal: hold the counter rather than wrap
        if (take) begin
          addr_cnt <= last ? addr_cnt : addr_cnt + ADDR_BITS'(4);
          count    <= count + 1'b1;
        end
        if (accept && err) imm_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder.
module tb_instr_encoder;
  import instr_encoder_pkg::*;
  logic clk = 0, rst = 1, start = 0, finish = 0, in_valid = 0, wr_ready = 0;
  logic [11:0] base_addr = '0;
  logic [2:0] in_fmt = '0;
  logic [6:0] in_opcode = '0, in_funct7 = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0] in_funct3 = '0;
  logic [31:0] in_imm = '0;
  logic in_ready, wr_valid, busy, full, imm_err;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [10:0] count;
  int checks = 0, failures = 0;

  instr_encoder #(.ADDR_BITS(12), .FMT_BITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .count(count), .busy(busy), .full(full),
    .imm_err(imm_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int f, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = 3'(f); in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1;
  endtask

  task automatic do_start(input logic [11:0] base);
    base_addr = base; start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if ({busy, full, imm_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, full, imm_err}); end
    checks++; if ({count, wr_addr, wr_data} !== '0) begin failures++; $display("FAIL reset_regs count=%h addr=%h data=%h exp 0", count, wr_addr, wr_data); end
    rst = 0;
    tick();
  endtask

  task automatic test_single();
    do_start(12'h100);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL start_in_ready got=%b exp=1", in_ready); end
    wr_ready = 0;
    drive(FORMAT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    in_valid = 0;
    checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL addi_wr_valid got=%b exp=1", wr_valid); end
    checks++; if (wr_addr !== 12'h100) begin failures++; $display("FAIL addi_addr got=%h exp=100", wr_addr); end
    checks++; if (wr_data !== 32'h00500093) begin failures++; $display("FAIL addi_data got=%h exp=00500093", wr_data); end
    wr_ready = 1;
    tick();
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL addi_retire got=%b exp=0", wr_valid); end
  endtask

  task automatic test_back_to_back();
    int fm[5] = '{NO_IMM, FORMAT_S, FORMAT_B, FORMAT_J, FORMAT_U};
    logic [6:0] op[5] = '{7'h33, 7'h23, 7'h63, 7'h6F, 7'h37};
    logic [4:0] rd[5] = '{5'd3, 5'd0, 5'd0, 5'd1, 5'd5};
    logic [2:0] f3[5] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
    logic [31:0] im[5] = '{32'd0, 32'd8, 32'd8, 32'd2048, 32'h12345000};
    logic [31:0] ex[5] = '{32'h002081B3, 32'h0020A423, 32'h00208463, 32'h001000EF, 32'h123452B7};
    wr_ready = 1;
    for (int i = 0; i < 5; i++) begin
      drive(fm[i], op[i], rd[i], 5'd1, 5'd2, f3[i], 7'd0, im[i]);
      tick();
      checks++; if (!wr_valid || wr_addr !== 12'(12'h104 + 4 * i) || wr_data !== ex[i]) begin
        failures++; $display("FAIL b2b_%0d valid=%b addr=%h data=%h exp addr=%h data=%h", i, wr_valid, wr_addr, wr_data, 12'(12'h104 + 4 * i), ex[i]);
      end
    end
    in_valid = 0;
    checks++; if (count !== 11'd6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", count); end
    tick();
  endtask

  task automatic test_backpressure();
    wr_ready = 0;
    drive(FORMAT_I, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    tick();
    drive(FORMAT_I, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0 || !wr_valid || wr_addr !== 12'h118 || wr_data !== 32'h00700113) begin
        failures++; $display("FAIL stall_%0d rdy=%b valid=%b addr=%h data=%h exp rdy=0 addr=118 data=00700113", i, in_ready, wr_valid, wr_addr, wr_data);
      end
      tick();
    end
    wr_ready = 1;
    tick();
    in_valid = 0;
    checks++; if (!wr_valid || wr_addr !== 12'h11C || wr_data !== 32'h00900193) begin
      failures++; $display("FAIL release valid=%b addr=%h data=%h exp addr=11c data=00900193", wr_valid, wr_addr, wr_data);
    end
    tick();
    checks++; if (wr_valid !== 1'b0 || count !== 11'd8) begin failures++; $display("FAIL release_count valid=%b count=%0d exp 0/8", wr_valid, count); end
  endtask

  task automatic test_finish();
    int n = 0;
    wr_ready = 0;
    drive(FORMAT_I, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    finish = 1;
    tick();
    finish = 0; in_valid = 0;
    checks++; if (!wr_valid || wr_addr !== 12'h120 || wr_data !== 32'h00100213 || count !== 11'd9) begin
      failures++; $display("FAIL finish_accept valid=%b addr=%h data=%h count=%0d exp addr=120 data=00100213 count=9", wr_valid, wr_addr, wr_data, count);
    end
    tick();
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL drain busy=%b rdy=%b exp 1/0", busy, in_ready); end
    wr_ready = 1;
    while (busy && n < 5) begin tick(); n++; end
    checks++; if (busy !== 1'b0 || wr_valid !== 1'b0) begin failures++; $display("FAIL drain_idle busy=%b valid=%b exp 0/0", busy, wr_valid); end
  endtask

  task automatic test_full();
    do_start(12'hFF8);
    wr_ready = 1;
    drive(FORMAT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    checks++; if (full !== 1'b0 || wr_addr !== 12'hFF8) begin failures++; $display("FAIL full_first full=%b addr=%h exp 0/ff8", full, wr_addr); end
    tick();
    checks++; if (full !== 1'b1 || in_ready !== 1'b0 || !wr_valid || wr_addr !== 12'hFFC) begin
      failures++; $display("FAIL full_set full=%b rdy=%b valid=%b addr=%h exp 1/0/1/ffc", full, in_ready, wr_valid, wr_addr);
    end
    tick();
    checks++; if (full !== 1'b1 || wr_valid !== 1'b0 || count !== 11'd2) begin
      failures++; $display("FAIL full_hold full=%b valid=%b count=%0d exp 1/0/2", full, wr_valid, count);
    end
    in_valid = 0;
    do_start(12'h203);
    checks++; if (full !== 1'b0 || in_ready !== 1'b1 || count !== 11'd0) begin
      failures++; $display("FAIL full_restart full=%b rdy=%b count=%0d exp 0/1/0", full, in_ready, count);
    end
    drive(FORMAT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    in_valid = 0;
    checks++; if (!wr_valid || wr_addr !== 12'h200 || wr_data !== 32'h00500093) begin
      failures++; $display("FAIL full_resume valid=%b addr=%h data=%h exp 200/00500093", wr_valid, wr_addr, wr_data);
    end
  endtask

  task automatic test_imm_range();
    drive(FORMAT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    tick();
`ifdef IMM_RANGE_CHECK_EN
    checks++; if (wr_valid !== 1'b0 || imm_err !== 1'b1 || count !== 11'd1) begin
      failures++; $display("FAIL imm_drop valid=%b err=%b count=%0d exp 0/1/1", wr_valid, imm_err, count);
    end
    drive(FORMAT_I, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    tick();
    in_valid = 0;
    checks++; if (!wr_valid || wr_addr !== 12'h204 || wr_data !== 32'h00700113 || imm_err !== 1'b1) begin
      failures++; $display("FAIL imm_next valid=%b addr=%h data=%h err=%b exp 1/204/00700113/1", wr_valid, wr_addr, wr_data, imm_err);
    end
`else
    in_valid = 0;
    checks++; if (!wr_valid || wr_addr !== 12'h204 || wr_data !== 32'h00000093 || imm_err !== 1'b0 || count !== 11'd2) begin
      failures++; $display("FAIL imm_trunc valid=%b addr=%h data=%h err=%b count=%0d exp 1/204/00000093/0/2", wr_valid, wr_addr, wr_data, imm_err, count);
    end
`endif
    tick();
  endtask

  task automatic test_rst_mid();
    do_start(12'h300);
    wr_ready = 0;
    drive(FORMAT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    tick();
    in_valid = 0;
    checks++; if (!wr_valid || wr_data !== 32'h123452B7) begin failures++; $display("FAIL rst_pre valid=%b data=%h exp 1/123452b7", wr_valid, wr_data); end
    rst = 1;
    tick();
    checks++; if (wr_valid !== 1'b0 || busy !== 1'b0 || count !== 11'd0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_mid valid=%b busy=%b count=%0d rdy=%b exp 0/0/0/0", wr_valid, busy, count, in_ready);
    end
    rst = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_finish();
    test_full();
    test_imm_range();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
